sti_dac_pgen: RTL and testbench

//  Parametrised serial-transmit / data-arrange engine. Latches one parallel word
//  per load and serialises an 8..(2*DW)-bit frame on so_data/so_valid.

---
 rtl/sti_dac_if.sv | 41 ++++
 rtl/sti_dac_pgen.sv | 173 +++++++++++++++++
 tb/tb_sti_dac_pgen.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sti_dac_if.sv
// sti_dac_if: bundles the stream-side and memory-side signals of sti_dac_pgen.
//   Producer side (master drives): load, pi_data, pi_length, pi_fill, pi_msb,
//     pi_low, pi_end.
//   Engine side (slave drives): busy, so_data, so_valid, oem_dataout, oem_addr,
//     oem_wr, oem_finish, dbg_state (current FSM state, for observation only).
// Handshake: a frame request is taken on a rising clock edge where load=1 and
//   busy=0; while busy=1 the load input is ignored. pi_end is taken only on an
//   edge where busy=0 and load=0.
interface sti_dac_if #(
  parameter int DW     = 16,
  parameter int BANKS  = 8,
  parameter int ADDR_W = 5
);
  logic              load;
  logic [DW-1:0]     pi_data;
  logic [1:0]        pi_length;
  logic              pi_fill;
  logic              pi_msb;
  logic              pi_low;
  logic              pi_end;
  logic              busy;
  logic              so_data;
  logic              so_valid;
  logic [7:0]        oem_dataout;
  logic [ADDR_W-1:0] oem_addr;
  logic [BANKS-1:0]  oem_wr;
  logic              oem_finish;
  logic [2:0]        dbg_state;

  modport master (
    output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
    input  busy, so_data, so_valid, oem_dataout, oem_addr, oem_wr, oem_finish,
    input  dbg_state
  );

  modport slave (
    input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
    output busy, so_data, so_valid, oem_dataout, oem_addr, oem_wr, oem_finish,
    output dbg_state
  );
endinterface

// File: rtl/sti_dac_pgen.sv
// sti_dac_pgen: serial-transmit / data-arrange engine.
//   Latches one parallel word per accepted load and shifts out an N-bit frame
//   (N = (pi_length+1)*DW/2) on so_data/so_valid, one bit per cycle. The same
//   bit stream is packed into bytes (first bit sent -> bit 7) and each byte is
//   written to one of BANKS byte memories in a checkerboard pattern. After
//   pi_end the engine lets the last write drain and raises sticky oem_finish.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high
//   bus   - sti_dac_if.slave (stream inputs, serial/memory outputs, dbg_state)
// Optional feature: define STI_DAC_CLEAR_EN to clear all banks (write 0 to
//   every address of every bank) for 2**ADDR_W cycles after each reset.
module sti_dac_pgen #(
  parameter int DW      = 16,
  parameter int BANKS   = 8,
  parameter int ADDR_W  = 5,
  parameter int ROW_PIX = 16
) (
  input logic      clk,
  input logic      reset,
  sti_dac_if.slave bus
);
  localparam int NW     = $clog2(2 * DW + 1);
  localparam int TOT    = BANKS * (2 ** ADDR_W);
  localparam int KW     = $clog2(TOT);
  localparam int RP_LOG = $clog2(ROW_PIX);

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_IDLE  = 3'd1,
    S_SHIFT = 3'd2,
    S_FLUSH = 3'd3,
    S_DONE  = 3'd4
  } state_t;

`ifdef STI_DAC_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
  logic [ADDR_W-1:0] clr_cnt;
`else
  localparam state_t RESET_STATE = S_IDLE;
`endif

  state_t          state;
  logic [2*DW-1:0] sr;        // remaining frame bits, next bit at the shift end
  logic            msb_q;
  logic [NW-1:0]   rem;       // bits still to send after the one on so_data
  logic [2:0]      bit_cnt;
  logic [7:0]      byte_sr;
  logic [KW-1:0]   k;

  // Frame build from the live inputs; only used on the accepting edge.
  logic [NW-1:0]   n_len;
  logic [DW/2-1:0] half;
  logic [2*DW-1:0] f;
  logic [2*DW-1:0] f_left;
  logic            first_bit;

  always_comb begin
    n_len = NW'((32'(bus.pi_length) + 32'd1) * (DW / 2));
    half  = bus.pi_low ? bus.pi_data[DW-1:DW/2] : bus.pi_data[DW/2-1:0];
    case (bus.pi_length)
      2'd0:    f = {{(DW + DW/2){1'b0}}, half};
      2'd1:    f = {{DW{1'b0}}, bus.pi_data};
      2'd2:    f = bus.pi_fill ? {{(DW/2){1'b0}}, bus.pi_data, {(DW/2){1'b0}}}
                               : {{DW{1'b0}}, bus.pi_data};
      default: f = bus.pi_fill ? {bus.pi_data, {DW{1'b0}}}
                               : {{DW{1'b0}}, bus.pi_data};
    endcase
    // Left-justify so MSB-first sending always reads the top bit.
    f_left    = f << (NW'(2 * DW) - n_len);
    first_bit = bus.pi_msb ? f_left[2*DW-1] : f[0];
  end

  // Byte and bank mapping for the byte index k.
  logic [7:0]       byte_nx;
  logic             sel;
  logic [KW-1:0]    pair_v;
  logic [KW:0]      bank_idx;
  logic [BANKS-1:0] wr_vec;

  always_comb begin
    byte_nx  = {byte_sr[6:0], bus.so_data};
    sel      = k[0] ^ k[RP_LOG];           // column parity xor row parity
    pair_v   = k >> (ADDR_W + 1);
    bank_idx = {pair_v, 1'b0} + {{KW{1'b0}}, sel};
    wr_vec   = BANKS'(1) << bank_idx;
  end

  assign bus.dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= RESET_STATE;
      bus.busy        <= 1'b0;
      bus.so_data     <= 1'b0;
      bus.so_valid    <= 1'b0;
      bus.oem_dataout <= '0;
      bus.oem_addr    <= '0;
      bus.oem_wr      <= '0;
      bus.oem_finish  <= 1'b0;
      sr              <= '0;
      msb_q           <= 1'b0;
      rem             <= '0;
      bit_cnt         <= '0;
      byte_sr         <= '0;
      k               <= '0;
`ifdef STI_DAC_CLEAR_EN
      clr_cnt         <= '0;
`endif
    end else begin
      bus.oem_wr <= '0;
      case (state)
`ifdef STI_DAC_CLEAR_EN
        S_CLEAR: begin
          bus.busy        <= 1'b1;
          bus.oem_wr      <= '1;
          bus.oem_dataout <= '0;
          bus.oem_addr    <= clr_cnt;
          clr_cnt         <= clr_cnt + 1'b1;
          if (clr_cnt == '1) state <= S_IDLE;
        end
`endif
        S_IDLE: begin
          bus.busy <= 1'b0;
          // busy is still 1 for one cycle after CLEAR; nothing is taken then.
          if (bus.load && !bus.busy) begin
            state        <= S_SHIFT;
            bus.busy     <= 1'b1;
            bus.so_valid <= 1'b1;
            bus.so_data  <= first_bit;
            msb_q        <= bus.pi_msb;
            sr           <= bus.pi_msb ? (f_left << 1) : (f >> 1);
            rem          <= n_len - 1'b1;
            bit_cnt      <= '0;
          end else if (bus.pi_end && !bus.busy) begin
            state <= S_FLUSH;
          end
        end
        S_SHIFT: begin
          byte_sr <= byte_nx;
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == 3'd7) begin
            bus.oem_wr      <= wr_vec;
            bus.oem_dataout <= byte_nx;
            bus.oem_addr    <= k[ADDR_W:1];
            k               <= (k == KW'(TOT - 1)) ? '0 : k + 1'b1;
          end
          if (rem == '0) begin
            state        <= S_IDLE;
            bus.busy     <= 1'b0;
            bus.so_valid <= 1'b0;
            bus.so_data  <= 1'b0;
          end else begin
            bus.so_data <= msb_q ? sr[2*DW-1] : sr[0];
            sr          <= msb_q ? (sr << 1) : (sr >> 1);
            rem         <= rem - 1'b1;
          end
        end
        S_FLUSH: begin
          // Writes only leave SHIFT; wait until the last pulse is gone.
          if (bus.oem_wr == '0) begin
            bus.oem_finish <= 1'b1;
            state          <= S_DONE;
          end
        end
        S_DONE: begin
          bus.oem_finish <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sti_dac_pgen.sv
module tb_sti_dac_pgen;
  localparam int DW      = 16;
  localparam int BANKS   = 8;
  localparam int ADDR_W  = 5;
  localparam int ROW_PIX = 16;
  localparam int TOT     = BANKS * (2 ** ADDR_W);

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sti_dac_if #(.DW(DW), .BANKS(BANKS), .ADDR_W(ADDR_W)) bus ();

  sti_dac_pgen #(.DW(DW), .BANKS(BANKS), .ADDR_W(ADDR_W), .ROW_PIX(ROW_PIX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int k_model = 0;
  logic [7:0]        exp_q[$];
  logic [7:0]        wr_log[$];
  logic [ADDR_W-1:0] addr_log[$];

  typedef struct {
    logic [15:0] d;
    logic [1:0]  len;
    logic        fill;
    logic        msb;
    logic        low;
    logic [31:0] exp;   // stream, first-sent bit at exp[n-1]
    int          n;
  } vec_t;
  vec_t vt[9];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] map_strobe(input int kk);
    int r, c, s, p;
    r = kk / ROW_PIX;
    c = kk % ROW_PIX;
    s = (c % 2) ^ (r % 2);
    p = kk >> (ADDR_W + 1);
    return 8'(1 << (2 * p + s));
  endfunction

  function automatic logic [ADDR_W-1:0] map_addr(input int kk);
    return ADDR_W'((kk >> 1) % (2 ** ADDR_W));
  endfunction

  // driver tasks
  task automatic do_reset();
    reset = 1'b1;
    bus.load = 1'b0; bus.pi_end = 1'b0; bus.pi_data = '0;
    bus.pi_length = '0; bus.pi_fill = 1'b0; bus.pi_msb = 1'b0; bus.pi_low = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_so_valid", bus.so_valid, 0);
    chk("rst_so_data", bus.so_data, 0);
    chk("rst_oem_wr", bus.oem_wr, 0);
    chk("rst_oem_addr", bus.oem_addr, 0);
    chk("rst_oem_dataout", bus.oem_dataout, 0);
    chk("rst_oem_finish", bus.oem_finish, 0);
`ifdef STI_DAC_CLEAR_EN
    for (int i = 0; i < 2 ** ADDR_W; i++) begin
      tick();
      chk("clr_wr", bus.oem_wr, 8'hFF);
      chk("clr_addr", bus.oem_addr, i);
      chk("clr_data", bus.oem_dataout, 0);
      chk("clr_busy", bus.busy, 1);
    end
    tick();
    chk("clr_busy_end", bus.busy, 0);
    chk("clr_wr_end", bus.oem_wr, 0);
`endif
    exp_q.delete();
    wr_log.delete();
    addr_log.delete();
    k_model = 0;
  endtask

  task automatic start_frame(input logic [15:0] d, input logic [1:0] len,
                             input logic fill, input logic msb, input logic low);
    bus.pi_data = d; bus.pi_length = len; bus.pi_fill = fill;
    bus.pi_msb = msb; bus.pi_low = low; bus.load = 1'b1;
    tick();
    bus.load = 1'b0;
  endtask

  // Called in cycle T+1; returns in cycle T+N+1 (last write pulse visible).
  task automatic check_stream(input logic [31:0] exp, input int n);
    for (int j = 0; j < n / 8; j++) exp_q.push_back(exp[(n - 1 - 8 * j) -: 8]);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        chk("so_valid", bus.so_valid, 1);
        chk("so_data", bus.so_data, exp[n - 1 - i]);
        chk("busy", bus.busy, 1);
      end else begin
        chk("so_valid_end", bus.so_valid, 0);
        chk("so_data_end", bus.so_data, 0);
        chk("busy_end", bus.busy, 0);
      end
      if (i > 0 && i % 8 == 0) begin
        chk("oem_wr", bus.oem_wr, map_strobe(k_model));
        chk("oem_addr", bus.oem_addr, map_addr(k_model));
        chk("oem_dataout", bus.oem_dataout, exp_q.pop_front());
        wr_log.push_back(bus.oem_wr);
        addr_log.push_back(bus.oem_addr);
        k_model = (k_model + 1) % TOT;
      end else begin
        chk("oem_wr_quiet", bus.oem_wr, 0);
      end
      if (i < n) tick();
    end
  endtask

  task automatic len0(input logic [7:0] b);
    start_frame({b, 8'h00}, 2'd0, 1'b0, 1'b1, 1'b1);
    check_stream(32'(b), 8);
  endtask

  task automatic len3(input logic [15:0] d);
    start_frame(d, 2'd3, 1'b0, 1'b1, 1'b0);
    check_stream({16'h0000, d}, 32);
  endtask

  initial begin
    vt[0] = '{16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1, 32'h000000A5, 8};
    vt[1] = '{16'h1234, 2'd0, 1'b0, 1'b0, 1'b0, 32'h0000002C, 8};
    vt[2] = '{16'hBEEF, 2'd1, 1'b0, 1'b1, 1'b0, 32'h0000BEEF, 16};
    vt[3] = '{16'h0001, 2'd3, 1'b0, 1'b0, 1'b0, 32'h80000000, 32};
    vt[4] = '{16'hC001, 2'd2, 1'b1, 1'b1, 1'b0, 32'h00C00100, 24};
    vt[5] = '{16'h8001, 2'd2, 1'b0, 1'b0, 1'b0, 32'h00800100, 24};
    vt[6] = '{16'h00F0, 2'd1, 1'b0, 1'b0, 1'b0, 32'h00000F00, 16};
    vt[7] = '{16'h1234, 2'd3, 1'b1, 1'b1, 1'b0, 32'h12340000, 32};
    vt[8] = '{16'h8421, 2'd0, 1'b0, 1'b0, 1'b1, 32'h00000021, 8};

    do_reset();

    // first byte after reset: A5 to bank 0, addr 0
    start_frame(16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1);
    check_stream(32'h000000A5, 8);
    chk("t1_wr", wr_log[0], 8'h01);
    chk("t1_addr", addr_log[0], 0);

    // 32-bit LSB-first frame: strobes alternate within the pair
    do_reset();
    start_frame(16'h0001, 2'd3, 1'b0, 1'b0, 1'b0);
    check_stream(32'h80000000, 32);
    chk("t2_wr0", wr_log[0], 8'h01);
    chk("t2_wr1", wr_log[1], 8'h02);
    chk("t2_wr2", wr_log[2], 8'h01);
    chk("t2_wr3", wr_log[3], 8'h02);
    chk("t2_addr0", addr_log[0], 0);
    chk("t2_addr1", addr_log[1], 0);
    chk("t2_addr2", addr_log[2], 1);
    chk("t2_addr3", addr_log[3], 1);

    // table of frames, all lengths and options
    do_reset();
    for (int v = 0; v < 9; v++) begin
      start_frame(vt[v].d, vt[v].len, vt[v].fill, vt[v].msb, vt[v].low);
      check_stream(vt[v].exp, vt[v].n);
    end

    // load held during a frame is ignored; taken right after, no gap bit
    start_frame(16'hBEEF, 2'd1, 1'b0, 1'b1, 1'b0);
    bus.pi_data = 16'h1234;
    bus.load = 1'b1;
    check_stream(32'h0000BEEF, 16);
    tick();
    bus.load = 1'b0;
    check_stream(32'h00001234, 16);

    // bank/row mapping and wrap of the byte index
    do_reset();
    for (int i = 0; i < 16; i++) len0(8'(i * 3 + 1));
    len0(8'h5A);
    chk("k16_wr", wr_log[$], 8'h02);
    chk("k16_addr", addr_log[$], 8);
    for (int i = 0; i < 3; i++) len3(16'(i * 37 + 5));
    for (int i = 0; i < 3; i++) len0(8'(i + 7));
    len0(8'hC3);
    chk("k32_wr", wr_log[$], 8'h01);
    chk("k32_addr", addr_log[$], 16);
    for (int i = 0; i < 7; i++) len3(16'(i * 91 + 3));
    for (int i = 0; i < 3; i++) len0(8'(i + 40));
    len0(8'h3C);
    chk("k64_wr", wr_log[$], 8'h04);
    chk("k64_addr", addr_log[$], 0);
    for (int i = 0; i < 47; i++) len3(16'(i * 613 + 11));
    for (int i = 0; i < 2; i++) len0(8'(i + 90));
    len0(8'h77);
    chk("k255_wr", wr_log[$], 8'h40);
    chk("k255_addr", addr_log[$], 31);
    len0(8'h99);
    chk("kwrap_wr", wr_log[$], 8'h01);
    chk("kwrap_addr", addr_log[$], 0);

    // load and pi_end together: load wins, pi_end dropped
    bus.pi_end = 1'b1;
    start_frame(16'h6600, 2'd0, 1'b0, 1'b1, 1'b1);
    bus.pi_end = 1'b0;
    check_stream(32'h00000066, 8);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("end_dropped", bus.oem_finish, 0);
    end

    // pi_end in the cycle of the last write pulse
    len0(8'hE7);
    bus.pi_end = 1'b1;
    tick();
    bus.pi_end = 1'b0;
    chk("finish_flush", bus.oem_finish, 0);
    tick();
    chk("finish_set", bus.oem_finish, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("finish_sticky", bus.oem_finish, 1);
      chk("finish_no_wr", bus.oem_wr, 0);
    end

    // reset in the middle of a 32-bit frame
    do_reset();
    start_frame(16'hFFFF, 2'd3, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) tick();
    reset = 1'b1;
    tick();
    chk("mid_busy", bus.busy, 0);
    chk("mid_so_valid", bus.so_valid, 0);
    chk("mid_so_data", bus.so_data, 0);
    chk("mid_wr", bus.oem_wr, 0);
    chk("mid_addr", bus.oem_addr, 0);
    chk("mid_data", bus.oem_dataout, 0);
    chk("mid_finish", bus.oem_finish, 0);
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("mid_no_wr", bus.oem_wr, 0);
      chk("mid_quiet", bus.so_valid, 0);
    end
    len0(8'h81);
    chk("mid_k0_wr", wr_log[$], 8'h01);
    chk("mid_k0_addr", addr_log[$], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // overall time bound
  initial begin
    #2000000;
    n_err++;
    $display("FAIL timeout: got no finish, expected end of test");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
